// File: rtl/down_seq.sv
// -----------------------------------------------------------------------------
// down_seq -- beat sequencer for the 64-to-32/16/8 bit DBUS downsizing mux.
//
// A write phrase transfer of a given data size is split into beats that match
// the target bus width. For each beat the sequencer drives the mux select
// lines (dmuxd) with the byte offset of that beat. It then waits for the bus
// cycle logic to ack the beat.
//
// Optional feature: define DOWN_SEQ_TIMEOUT_EN to enable the stall timeout.
// A beat that stays un-acked for TIMEOUT_CYCLES consecutive cycles aborts the
// transfer with a one-cycle err pulse. Without the macro, err is tied to 0.
//
// Ports:
//   sys_clk    in   system clock, rising edge
//   reset      in   synchronous active-high reset
//   req        in   transfer request, level-sampled in IDLE only
//   size [1:0] in   data size code: 0=8, 1=16, 2=32, 3=64 bit
//   bwidth[1:0]in   bus width code: 0=8, 1=16, 2=32 bit (3 is treated as 32)
//   addr [2:0] in   byte offset of the transfer within the 64-bit phrase
//   ack        in   bus has taken the current beat
//   accept     out  one-cycle pulse when a request is latched
//   busy       out  high while beats are being sequenced
//   beat_valid out  a beat is presented on the bus
//   dmuxd[2:0] out  mux selects, byte offset of the current beat
//   last       out  current beat is the final one
//   done       out  one-cycle completion pulse
//   err        out  one-cycle timeout pulse
// -----------------------------------------------------------------------------
module down_seq #(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic       sys_clk,
   input  logic       reset,
   input  logic       req,
   input  logic [1:0] size,
   input  logic [1:0] bwidth,
   input  logic [2:0] addr,
   input  logic       ack,
   output logic       accept,
   output logic       busy,
   output logic       beat_valid,
   output logic [2:0] dmuxd,
   output logic       last,
   output logic       done,
   output logic       err
);

`ifdef DOWN_SEQ_TIMEOUT_EN
   typedef enum logic [1:0] {IDLE, XFER, DONE, ERR} state_t;
`else
   typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;
`endif

   state_t state, next_state;

   // Latched transfer state.
   logic [1:0] bw_q;        // effective bus width code, 0..2
   logic [2:0] cur_off;     // byte offset of the current beat
   logic [3:0] beats_left;  // beats still to be acked, 1..8

   // Request decode.
   logic [1:0] bw_eff;
   logic [2:0] off_in;
   logic [3:0] beats_in;
   logic [2:0] bb_step;

   // Mask that clears the byte-offset bits below a power-of-two width code.
   // A 64-bit width (code 3) clears every bit.
   function automatic logic [2:0] low_mask(input logic [1:0] code);
      case (code)
         2'd0:    low_mask = 3'b111;
         2'd1:    low_mask = 3'b110;
         2'd2:    low_mask = 3'b100;
         default: low_mask = 3'b000;
      endcase
   endfunction

   always_comb begin
      // NOTE: every always_comb output gets a default first, so no path can leave it unassigned and infer a latch.
      bw_eff   = (bwidth == 2'd3) ? 2'd2 : bwidth;
      off_in   = addr & low_mask(size);
      beats_in = 4'd1;
      if (size > bw_eff)
         beats_in = 4'd1 << (size - bw_eff);
      bb_step  = 3'd1 << bw_q;
   end

`ifdef DOWN_SEQ_TIMEOUT_EN
   logic [7:0] stall_cnt;
   logic       stall_hit;

   // The stall counter clears when XFER is entered and on every ack.
   always_ff @(posedge sys_clk) begin
      if (reset)
         stall_cnt <= '0;
      else if (state == XFER && !ack)
         stall_cnt <= stall_cnt + 8'd1;
      else
         stall_cnt <= '0;
   end

   // The counter reaches TIMEOUT_CYCLES on this edge, so the abort happens now.
   assign stall_hit = (stall_cnt == 8'(TIMEOUT_CYCLES - 1));
`endif

   // State register.
   always_ff @(posedge sys_clk) begin
      // NOTE: sequential state uses non-blocking assignments, so every flop samples pre-edge values.
      if (reset)
         state <= IDLE;
      else
         state <= next_state;
   end

   // Next-state logic.
   always_comb begin
      next_state = state;
      case (state)
         IDLE: if (req) next_state = XFER;
         XFER: begin
            if (ack) begin
               if (beats_left == 4'd1)
                  next_state = DONE;
            end
`ifdef DOWN_SEQ_TIMEOUT_EN
            else if (stall_hit) begin
               next_state = ERR;
            end
`endif
         end
         DONE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Transfer datapath.
   always_ff @(posedge sys_clk) begin
      // NOTE: these registers are reset because a restarted sequencer must not carry offsets from an aborted transfer.
      if (reset) begin
         bw_q       <= '0;
         cur_off    <= '0;
         beats_left <= '0;
      end else if (state == IDLE && req) begin
         bw_q       <= bw_eff;
         cur_off    <= off_in;
         beats_left <= beats_in;
      end else if (state == XFER && ack && beats_left > 4'd1) begin
         // A 3-bit add wraps mod 8, which keeps the offset inside the phrase.
         cur_off    <= cur_off + bb_step;
         beats_left <= beats_left - 4'd1;
      end
   end

   // Output logic.
   always_comb begin
      accept     = 1'b0;
      busy       = 1'b0;
      beat_valid = 1'b0;
      dmuxd      = 3'd0;
      last       = 1'b0;
      done       = 1'b0;
      err        = 1'b0;
      case (state)
         // Gate with reset so that no accept is shown for a request that will not be latched.
         IDLE: accept = req & ~reset;
         XFER: begin
            busy       = 1'b1;
            beat_valid = 1'b1;
            dmuxd      = cur_off & low_mask(bw_q);
            last       = (beats_left == 4'd1);
         end
         DONE: done = 1'b1;
`ifdef DOWN_SEQ_TIMEOUT_EN
         ERR:  err  = 1'b1;
`endif
         default: ;
      endcase
   end

endmodule

// File: tb/tb_down_seq.sv
// -----------------------------------------------------------------------------
// tb_down_seq -- directed self-checking bench for down_seq.
// Inputs change 1 time unit after the rising edge. Outputs are checked 1 time
// unit later, well away from the next edge.
// -----------------------------------------------------------------------------
module tb_down_seq;

   logic       sys_clk = 1'b0;
   logic       reset;
   logic       req;
   logic [1:0] size;
   logic [1:0] bwidth;
   logic [2:0] addr;
   logic       ack;
   logic       accept;
   logic       busy;
   logic       beat_valid;
   logic [2:0] dmuxd;
   logic       last;
   logic       done;
   logic       err;

   int checks = 0;
   int errors = 0;

   always #5 sys_clk = ~sys_clk;

   down_seq #(.TIMEOUT_CYCLES(4)) dut (
      .sys_clk    (sys_clk),
      .reset      (reset),
      .req        (req),
      .size       (size),
      .bwidth     (bwidth),
      .addr       (addr),
      .ack        (ack),
      .accept     (accept),
      .busy       (busy),
      .beat_valid (beat_valid),
      .dmuxd      (dmuxd),
      .last       (last),
      .done       (done),
      .err        (err)
   );

   task automatic step();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Checks all outputs at once. Packing order: accept, busy, beat_valid, last, done, err, dmuxd.
   task automatic chk(input string tag, input logic acc, input logic xf, input logic [2:0] dm,
                      input logic lst, input logic dn, input logic er);
      #1;
      check(tag, {23'd0, accept, busy, beat_valid, last, done, err, dmuxd},
                 {23'd0, acc, xf, xf, lst, dn, er, dm});
   endtask

   task automatic chk_idle(input string tag);
      chk(tag, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic request(input logic [1:0] s, input logic [1:0] bw, input logic [2:0] a);
      req = 1'b1; size = s; bwidth = bw; addr = a;
   endtask

   initial begin
      reset = 1'b1; req = 1'b0; size = '0; bwidth = '0; addr = '0; ack = 1'b0;
      step(); step();
      chk_idle("reset_state");
      reset = 1'b0;
      step();
      chk_idle("idle_after_reset");

      // Eight byte beats: size=64, bus=8, addr=5 -> off=0, dmuxd 0..7.
      request(2'd3, 2'd0, 3'd5); ack = 1'b1;
      chk("t1_accept", 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
      step(); req = 1'b0;
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("t1_beat%0d", i), 1'b0, 1'b1, 3'(i), (i == 7), 1'b0, 1'b0);
         step();
      end
      chk("t1_done", 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0);
      step();
      chk_idle("t1_idle");

      // Two 16-bit beats: size=32, bus=16, addr=6 -> off=4, dmuxd 4 then 6.
      request(2'd2, 2'd1, 3'd6);
      chk("t2_accept", 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
      step(); req = 1'b0;
      chk("t2_beat0", 1'b0, 1'b1, 3'd4, 1'b0, 1'b0, 1'b0);
      step();
      chk("t2_beat1", 1'b0, 1'b1, 3'd6, 1'b1, 1'b0, 1'b0);
      step();
      chk("t2_done", 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0);
      step();

      // Size narrower than the bus: size=16, addr=7 -> off=6, one beat with dmuxd=4.
      // bwidth=2 and the reserved code 3 must give the same result.
      for (int bw = 2; bw <= 3; bw++) begin
         request(2'd1, 2'(bw), 3'd7);
         chk($sformatf("t3_accept_bw%0d", bw), 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
         step(); req = 1'b0;
         chk($sformatf("t3_beat_bw%0d", bw), 1'b0, 1'b1, 3'd4, 1'b1, 1'b0, 1'b0);
         step();
         chk($sformatf("t3_done_bw%0d", bw), 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0);
         step();
      end

      // Stall plus a request while busy: size=32, bus=8, addr=0 -> dmuxd 0,1,2,3.
      request(2'd2, 2'd0, 3'd0); ack = 1'b1;
      chk("t4_accept", 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
      step(); req = 1'b0;
      chk("t4_beat0", 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0);
      step(); ack = 1'b0;
      for (int i = 0; i < 3; i++) begin
         // A request during XFER uses a different size and must be ignored.
         if (i == 1) request(2'd3, 2'd2, 3'd0);
         else        req = 1'b0;
         chk($sformatf("t4_stall%0d", i), 1'b0, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0);
         step();
      end
      req = 1'b0; ack = 1'b1;
      chk("t4_beat1", 1'b0, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0);
      step();
      chk("t4_beat2", 1'b0, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0);
      step();
      chk("t4_beat3", 1'b0, 1'b1, 3'd3, 1'b1, 1'b0, 1'b0);
      step();
      // A request held during DONE is accepted only in the following cycle.
      request(2'd0, 2'd0, 3'd3);
      chk("t4_done_no_accept", 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0);
      step();
      chk("t4_accept_after_done", 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
      step(); req = 1'b0;
      chk("t4_byte_beat", 1'b0, 1'b1, 3'd3, 1'b1, 1'b0, 1'b0);
      step();
      chk("t4_byte_done", 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0);
      step();

      // Reset after 2 of 8 acked beats.
      request(2'd3, 2'd0, 3'd0);
      step(); req = 1'b0;
      chk("t5_beat0", 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0);
      step();
      chk("t5_beat1", 1'b0, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0);
      step();
      reset = 1'b1;
      step(); reset = 1'b0;
      chk_idle("t5_after_reset");
      step();
      chk_idle("t5_no_done");
      request(2'd1, 2'd0, 3'd2);
      chk("t5_accept", 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
      step(); req = 1'b0;
      chk("t5_beat_a", 1'b0, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0);
      step();
      chk("t5_beat_b", 1'b0, 1'b1, 3'd3, 1'b1, 1'b0, 1'b0);
      step();
      chk("t5_done", 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0);
      step();

      // Timeout: size=64, bus=32, ack never asserted.
      ack = 1'b0;
      request(2'd3, 2'd2, 3'd0);
      step(); req = 1'b0;
`ifdef DOWN_SEQ_TIMEOUT_EN
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("t6_stall%0d", i), 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0);
         step();
      end
      chk("t6_err", 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
      step();
      chk_idle("t6_idle");
`else
      for (int i = 0; i < 110; i++) begin
         chk($sformatf("t6_wait%0d", i), 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0);
         step();
      end
      reset = 1'b1;
      step(); reset = 1'b0;
      chk_idle("t6_idle");
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
